irq_encoder8: RTL and testbench

- 8-source event encoder and presenter; the reverse direction of the 3-to-8 write-enable decoder.
- Collects one-hot/multi-hot request lines into a sticky pending register and priority-encodes the winner to a 3-bit id.
- Presents the id to the pipeline's exception/IRQ stage under a valid/ack handshake.
- Sits between peripheral/exception sources and the CPU control stage.

---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_encoder8_prio_enc8.sv | 29 ++
 rtl/irq_encoder8.sv | 84 ++++++++
 tb/tb_irq_encoder8.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants, state encoding and helpers for the 8-source IRQ encoder.
package irq_pkg;

  localparam int N_SRC = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic logic [N_SRC-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [N_SRC-1:0] vec;
    vec     = '0;
    vec[id] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/irq_encoder8_prio_enc8.sv
// Rotating priority encoder: first set bit of eligible scanning upward from start, wrapping 7->0.
module prio_enc8
  import irq_pkg::*;
(
  input  logic [N_SRC-1:0] eligible,
  input  logic [ID_W-1:0]  start,
  output logic             found,
  output logic [ID_W-1:0]  idx
);

  logic [2*N_SRC-1:0] dbl;
  logic [N_SRC-1:0]   rot;

  assign dbl = {eligible, eligible} >> start;
  assign rot = dbl[N_SRC-1:0];

  // Descending scan so the lowest rotated position is the last assignment to land.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        idx   = start + ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/irq_encoder8.sv
// 8-source sticky-pending IRQ encoder presenting a 3-bit id under a valid/ack handshake.
//   state   | meaning
//   IDLE    | nothing presented; select a winner from pending & mask
//   PRESENT | irq_id held stable with irq_valid=1 until ack
module irq_encoder8
  import irq_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] req,
  input  logic [N_SRC-1:0] mask,
  input  logic             ack,
  input  logic             ovf_clr,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] overflow
);

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [N_SRC-1:0] clr_vec;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] ovf_set;
  logic [ID_W-1:0]  start;
  logic             found;
  logic [ID_W-1:0]  win_idx;

  assign clr_vec  = (state == PRESENT && ack) ? id_onehot(irq_id) : '0;
  // A bit being acked this cycle is not an overflow even if req re-fires on it.
  assign ovf_set  = req & pending & ~clr_vec;
  assign eligible = pending & mask;
  assign start    = (RR_EN != 0) ? rr_ptr : '0;

  prio_enc8 u_prio (
    .eligible (eligible),
    .start    (start),
    .found    (found),
    .idx      (win_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      overflow <= '0;
    end else begin
      pending  <= (pending & ~clr_vec) | req;
      overflow <= ovf_clr ? ovf_set : (overflow | ovf_set);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      irq_valid <= 1'b0;
      irq_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= PRESENT;
            irq_id    <= win_idx;
            irq_valid <= 1'b1;
          end
        end
        PRESENT: begin
          if (ack) begin
            state     <= IDLE;
            irq_valid <= 1'b0;
            rr_ptr    <= irq_id + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          irq_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_encoder8.sv
// Directed bench for irq_encoder8: round-robin instance plus a fixed-priority instance on shared stimulus.
module tb_irq_encoder8;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] mask = '0;
  logic       ack = 1'b0;
  logic       ovf_clr = 1'b0;

  logic       irq_valid, irq_valid_fp;
  logic [2:0] irq_id, irq_id_fp;
  logic [7:0] pending, pending_fp;
  logic [7:0] overflow, overflow_fp;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  irq_encoder8 #(.RR_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .mask(mask), .ack(ack), .ovf_clr(ovf_clr),
    .irq_valid(irq_valid), .irq_id(irq_id), .pending(pending), .overflow(overflow)
  );

  irq_encoder8 #(.RR_EN(0)) dut_fp (
    .clk(clk), .reset_n(reset_n), .req(req), .mask(mask), .ack(ack), .ovf_clr(ovf_clr),
    .irq_valid(irq_valid_fp), .irq_id(irq_id_fp), .pending(pending_fp), .overflow(overflow_fp)
  );

  typedef struct {
    string      name;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic       ovf_clr;
    logic       exp_valid;
    logic [2:0] exp_id;
    logic [7:0] exp_pending;
    logic [7:0] exp_overflow;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; mask = '0; ack = 1'b0; ovf_clr = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic drive(input logic [7:0] r, input logic [7:0] m, input logic a, input logic c);
    req = r; mask = m; ack = a; ovf_clr = c;
  endtask

  vec_t vecs[$];
  logic [7:0] exp_pend;

  initial begin
    // Single event: pending one edge after req, presented one edge later, held until ack.
    vecs.push_back('{"single_pend",  8'h10, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 8'h10, 8'h00});
    vecs.push_back('{"single_pres",  8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10, 8'h00});
    vecs.push_back('{"single_hold",  8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10, 8'h00});
    vecs.push_back('{"single_ack",   8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00});
    vecs.push_back('{"single_quiet", 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00});

    #2;
    chk("reset_valid", {31'd0, irq_valid}, 32'd0);
    chk("reset_id", {29'd0, irq_id}, 32'd0);
    chk("reset_pending", {24'd0, pending}, 32'd0);
    chk("reset_overflow", {24'd0, overflow}, 32'd0);
    do_reset();

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].mask, vecs[i].ack, vecs[i].ovf_clr);
      tick();
      chk({vecs[i].name, "_valid"}, {31'd0, irq_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid)
        chk({vecs[i].name, "_id"}, {29'd0, irq_id}, {29'd0, vecs[i].exp_id});
      chk({vecs[i].name, "_pending"}, {24'd0, pending}, {24'd0, vecs[i].exp_pending});
      chk({vecs[i].name, "_overflow"}, {24'd0, overflow}, {24'd0, vecs[i].exp_overflow});
    end

    // Round-robin with all eight pending.
    do_reset();
    drive(8'hFF, 8'hFF, 1'b0, 1'b0);
    tick();
    chk("rr_load_valid", {31'd0, irq_valid}, 32'd0);
    exp_pend = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      drive(8'h00, 8'hFF, 1'b0, 1'b0);
      tick();
      chk($sformatf("rr_valid_%0d", i), {31'd0, irq_valid}, 32'd1);
      chk($sformatf("rr_id_%0d", i), {29'd0, irq_id}, i);
      ack = 1'b1;
      tick();
      exp_pend[i] = 1'b0;
      chk($sformatf("rr_gap_%0d", i), {31'd0, irq_valid}, 32'd0);
      chk($sformatf("rr_pend_%0d", i), {24'd0, pending}, {24'd0, exp_pend});
    end
    ack = 1'b0;
    tick();
    chk("rr_end_valid", {31'd0, irq_valid}, 32'd0);

    // Fixed priority: req[0] arrives with the ack of id 1, so it beats pending id 3.
    do_reset();
    drive(8'h0A, 8'hFF, 1'b0, 1'b0);
    tick();
    drive(8'h00, 8'hFF, 1'b0, 1'b0);
    tick();
    chk("fp_first_valid", {31'd0, irq_valid_fp}, 32'd1);
    chk("fp_first_id", {29'd0, irq_id_fp}, 32'd1);
    drive(8'h01, 8'hFF, 1'b1, 1'b0);
    tick();
    chk("fp_gap_valid", {31'd0, irq_valid_fp}, 32'd0);
    chk("fp_gap_pending", {24'd0, pending_fp}, 32'h09);
    drive(8'h00, 8'hFF, 1'b0, 1'b0);
    tick();
    chk("fp_second_id", {29'd0, irq_id_fp}, 32'd0);
    chk("rr_contrast_id", {29'd0, irq_id}, 32'd3);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    chk("fp_third_valid", {31'd0, irq_valid_fp}, 32'd1);
    chk("fp_third_id", {29'd0, irq_id_fp}, 32'd3);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("fp_end_pending", {24'd0, pending_fp}, 32'h00);

    // Presented id is not retracted when its mask drops.
    do_reset();
    drive(8'h20, 8'hFF, 1'b0, 1'b0);
    tick();
    drive(8'h00, 8'hFF, 1'b0, 1'b0);
    tick();
    chk("mask_pres_id", {29'd0, irq_id}, 32'd5);
    mask = 8'hDF;
    tick();
    tick();
    chk("mask_hold_valid", {31'd0, irq_valid}, 32'd1);
    chk("mask_hold_id", {29'd0, irq_id}, 32'd5);
    ack = 1'b1;
    tick();
    chk("mask_ack_valid", {31'd0, irq_valid}, 32'd0);
    drive(8'h21, 8'h00, 1'b0, 1'b0);
    tick();
    req = 8'h00;
    tick();
    tick();
    chk("masked_valid", {31'd0, irq_valid}, 32'd0);
    chk("masked_pending", {24'd0, pending}, 32'h21);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("idle_ack_pending", {24'd0, pending}, 32'h21);
    chk("idle_ack_valid", {31'd0, irq_valid}, 32'd0);
    mask = 8'hFF;
    tick();
    chk("unmask_valid", {31'd0, irq_valid}, 32'd1);
    chk("unmask_rr_id", {29'd0, irq_id}, 32'd0);

    // Overflow and same-cycle set/clear interactions.
    do_reset();
    drive(8'h04, 8'hFF, 1'b0, 1'b0);
    tick();
    chk("ovf_first", {24'd0, overflow}, 32'h00);
    tick();
    chk("ovf_set", {24'd0, overflow}, 32'h04);
    chk("ovf_pres_id", {29'd0, irq_id}, 32'd2);
    ack = 1'b1;
    tick();
    chk("ovf_ackreq_pending", {24'd0, pending}, 32'h04);
    chk("ovf_ackreq_overflow", {24'd0, overflow}, 32'h04);
    drive(8'h00, 8'hFF, 1'b0, 1'b0);
    tick();
    chk("ovf_repres_id", {29'd0, irq_id}, 32'd2);
    ovf_clr = 1'b1;
    tick();
    chk("ovf_clr", {24'd0, overflow}, 32'h00);
    req = 8'h04;
    tick();
    chk("ovf_set_beats_clr", {24'd0, overflow}, 32'h04);
    drive(8'h08, 8'hFF, 1'b0, 1'b0);
    tick();
    req = 8'h00;

    // Asynchronous reset while presenting.
    chk("arst_pre_valid", {31'd0, irq_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, irq_valid}, 32'd0);
    chk("arst_pending", {24'd0, pending}, 32'h00);
    chk("arst_overflow", {24'd0, overflow}, 32'h00);
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    tick();
    chk("arst_after_valid", {31'd0, irq_valid}, 32'd0);
    chk("arst_after_pending", {24'd0, pending}, 32'h00);
    chk("arst_after_id", {29'd0, irq_id}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
